// File: rtl/hd44780_sink_if.sv
// HD44780 4-bit write bus (e/rs/db) as seen between driver and panel.
// master drives the bus; slave is the panel-side receiver.
interface hd44780_sink_if;
  logic       e;
  logic       rs;
  logic [3:0] db;

  modport master (output e, rs, db);
  modport slave  (input  e, rs, db);
endinterface

// File: rtl/hd44780_sink.sv
// Panel-side HD44780 4-bit write receiver: strobe detect, nibble assembly, decode.
// Optional busy model enabled with macro HD44780_SINK_BUSY_EN.
module hd44780_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int E_MIN_HIGH  = 4,
  parameter int BUSY_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  hd44780_sink_if.slave        lcd,
  output logic                 mode4,
  output logic                 byte_valid,
  output logic [7:0]           byte_out,
  output logic                 byte_rs,
  output logic                 ddram_we,
  output logic [6:0]           ddram_addr,
  output logic [7:0]           ddram_wdata,
  output logic [6:0]           addr,
  output logic                 clear_pulse,
  output logic                 busy,
  output logic                 err_busy
);

  localparam int HW = $clog2(E_MIN_HIGH + 1);
  localparam logic [HW-1:0] HI_MAX = HW'(E_MIN_HIGH);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (BUSY_CYCLES < 1) begin : g_bad_busy
    $error("BUSY_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    INIT8  = 2'd0,
    NIB_HI = 2'd1,
    NIB_LO = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]      e_sync_q, e_sync_d;
  logic [SYNC_STAGES-1:0]      rs_sync_q, rs_sync_d;
  logic [SYNC_STAGES-1:0][3:0] db_sync_q, db_sync_d;
  logic                        e_s, rs_s;
  logic [3:0]                  db_s;

  state_t        state_q, state_d;
  logic [HW-1:0] hi_cnt_q, hi_cnt_d;
  logic          rs_l_q, rs_l_d;
  logic [3:0]    db_l_q, db_l_d;
  logic [3:0]    hi_nib_q, hi_nib_d;
  logic          hi_rs_q, hi_rs_d;
  logic          id_q, id_d;
  logic [6:0]    ac_q, ac_d;
  logic          mode4_q, mode4_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_rs_q, byte_rs_d;
  logic          ddram_we_q, ddram_we_d;
  logic [6:0]    ddram_addr_q, ddram_addr_d;
  logic [7:0]    ddram_wdata_q, ddram_wdata_d;
  logic          clear_pulse_q, clear_pulse_d;

  logic          strobe;
  logic          have_byte;
  logic          is_clear;
  logic [7:0]    byte_v;
  logic          brs;

  assign e_s  = e_sync_q[SYNC_STAGES-1];
  assign rs_s = rs_sync_q[SYNC_STAGES-1];
  assign db_s = db_sync_q[SYNC_STAGES-1];

  // Synchronizer shift chains for the asynchronous bus inputs.
  always_comb begin
    e_sync_d  = {e_sync_q[SYNC_STAGES-2:0], lcd.e};
    rs_sync_d = {rs_sync_q[SYNC_STAGES-2:0], lcd.rs};
    db_sync_d = {db_sync_q[SYNC_STAGES-2:0], lcd.db};
  end

  // Strobe detection, interface-mode FSM, byte assembly and decode.
  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    rs_l_d        = rs_l_q;
    db_l_d        = db_l_q;
    hi_nib_d      = hi_nib_q;
    hi_rs_d       = hi_rs_q;
    id_d          = id_q;
    ac_d          = ac_q;
    mode4_d       = mode4_q;
    byte_valid_d  = 1'b0;
    byte_out_d    = byte_out_q;
    byte_rs_d     = byte_rs_q;
    ddram_we_d    = 1'b0;
    ddram_addr_d  = ddram_addr_q;
    ddram_wdata_d = ddram_wdata_q;
    clear_pulse_d = 1'b0;
    strobe        = 1'b0;
    have_byte     = 1'b0;
    is_clear      = 1'b0;
    byte_v        = 8'h00;
    brs           = 1'b0;

    if (e_s) begin
      rs_l_d = rs_s;
      db_l_d = db_s;
      if (hi_cnt_q != HI_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
    end else begin
      hi_cnt_d = '0;
      strobe   = (hi_cnt_q == HI_MAX);
    end

    if (strobe) begin
      unique case (state_q)
        INIT8: begin
          have_byte = 1'b1;
          byte_v    = {db_l_q, 4'b0000};
          brs       = rs_l_q;
          if (!brs && byte_v[7:5] == 3'b001 && !byte_v[4]) begin
            state_d = NIB_HI;
            mode4_d = 1'b1;
          end
        end
        NIB_HI: begin
          hi_nib_d = db_l_q;
          hi_rs_d  = rs_l_q;
          state_d  = NIB_LO;
        end
        NIB_LO: begin
          have_byte = 1'b1;
          byte_v    = {hi_nib_q, db_l_q};
          brs       = hi_rs_q;
          state_d   = NIB_HI;
          if (!brs && byte_v[7:5] == 3'b001 && byte_v[4]) begin
            state_d = INIT8;
            mode4_d = 1'b0;
          end
        end
        default: state_d = INIT8;
      endcase
    end

    if (have_byte) begin
      byte_valid_d = 1'b1;
      byte_out_d   = byte_v;
      byte_rs_d    = brs;
      unique case (1'b1)
        brs: begin
          ddram_we_d    = 1'b1;
          ddram_addr_d  = ac_q;
          ddram_wdata_d = byte_v;
          ac_d          = id_q ? ac_q + 7'd1 : ac_q - 7'd1;
        end
        (!brs && byte_v == 8'h01): begin
          ac_d          = 7'd0;
          id_d          = 1'b1;
          clear_pulse_d = 1'b1;
          is_clear      = 1'b1;
        end
        (!brs && byte_v[7:1] == 7'b0000001): ac_d = 7'd0;
        (!brs && byte_v[7:2] == 6'b000001):  id_d = byte_v[1];
        (!brs && byte_v[7]):                 ac_d = byte_v[6:0];
        default: ;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_sync_q      <= '0;
      rs_sync_q     <= '0;
      db_sync_q     <= '0;
      state_q       <= INIT8;
      hi_cnt_q      <= '0;
      rs_l_q        <= 1'b0;
      db_l_q        <= 4'h0;
      hi_nib_q      <= 4'h0;
      hi_rs_q       <= 1'b0;
      id_q          <= 1'b1;
      ac_q          <= 7'd0;
      mode4_q       <= 1'b0;
      byte_valid_q  <= 1'b0;
      byte_out_q    <= 8'h00;
      byte_rs_q     <= 1'b0;
      ddram_we_q    <= 1'b0;
      ddram_addr_q  <= 7'd0;
      ddram_wdata_q <= 8'h00;
      clear_pulse_q <= 1'b0;
    end else begin
      e_sync_q      <= e_sync_d;
      rs_sync_q     <= rs_sync_d;
      db_sync_q     <= db_sync_d;
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      rs_l_q        <= rs_l_d;
      db_l_q        <= db_l_d;
      hi_nib_q      <= hi_nib_d;
      hi_rs_q       <= hi_rs_d;
      id_q          <= id_d;
      ac_q          <= ac_d;
      mode4_q       <= mode4_d;
      byte_valid_q  <= byte_valid_d;
      byte_out_q    <= byte_out_d;
      byte_rs_q     <= byte_rs_d;
      ddram_we_q    <= ddram_we_d;
      ddram_addr_q  <= ddram_addr_d;
      ddram_wdata_q <= ddram_wdata_d;
      clear_pulse_q <= clear_pulse_d;
    end
  end

  assign mode4       = mode4_q;
  assign byte_valid  = byte_valid_q;
  assign byte_out    = byte_out_q;
  assign byte_rs     = byte_rs_q;
  assign ddram_we    = ddram_we_q;
  assign ddram_addr  = ddram_addr_q;
  assign ddram_wdata = ddram_wdata_q;
  assign addr        = ac_q;
  assign clear_pulse = clear_pulse_q;

`ifdef HD44780_SINK_BUSY_EN
  localparam int BW = $clog2(4 * BUSY_CYCLES + 1);
  localparam logic [BW-1:0] BUSY_LD = BW'(BUSY_CYCLES);
  localparam logic [BW-1:0] CLR_LD  = BW'(4 * BUSY_CYCLES);

  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic          err_busy_q, err_busy_d;

  // Busy countdown, reloaded by every byte; Clear holds it four times longer.
  always_comb begin
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;
    err_busy_d = err_busy_q;
    if (strobe && busy_cnt_q != '0) err_busy_d = 1'b1;
    if (have_byte) busy_cnt_d = is_clear ? CLR_LD : BUSY_LD;
  end

  // Busy counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_q <= '0;
      err_busy_q <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      err_busy_q <= err_busy_d;
    end
  end

  assign busy     = (busy_cnt_q != '0);
  assign err_busy = err_busy_q;
`else
  assign busy     = 1'b0;
  assign err_busy = 1'b0;
`endif

endmodule

// File: tb/tb_hd44780_sink.sv
// Directed table-driven bench for hd44780_sink.
// Busy checks compile only with HD44780_SINK_BUSY_EN.
module tb_hd44780_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode4, byte_valid, byte_rs, ddram_we, clear_pulse;
  logic       busy, err_busy;
  logic [7:0] byte_out, ddram_wdata;
  logic [6:0] ddram_addr, addr;

  int tests = 0;
  int fails = 0;

  int         bv_cnt = 0;
  int         we_cnt = 0;
  int         clr_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_rs = 1'b0;
  logic [6:0] last_wa = 7'd0;
  logic [7:0] last_wd = 8'h00;

  hd44780_sink_if lcd ();

  hd44780_sink dut (
    .clk         (clk),
    .rst         (rst),
    .lcd         (lcd.slave),
    .mode4       (mode4),
    .byte_valid  (byte_valid),
    .byte_out    (byte_out),
    .byte_rs     (byte_rs),
    .ddram_we    (ddram_we),
    .ddram_addr  (ddram_addr),
    .ddram_wdata (ddram_wdata),
    .addr        (addr),
    .clear_pulse (clear_pulse),
    .busy        (busy),
    .err_busy    (err_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt    = bv_cnt + 1;
      last_byte = byte_out;
      last_rs   = byte_rs;
    end
    if (ddram_we) begin
      we_cnt  = we_cnt + 1;
      last_wa = ddram_addr;
      last_wd = ddram_wdata;
    end
    if (clear_pulse) clr_cnt = clr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic r, input logic [3:0] d, input int hi);
    @(negedge clk);
    lcd.rs = r;
    lcd.db = d;
    lcd.e  = 1'b1;
    repeat (hi) @(negedge clk);
    lcd.e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       r;
    logic [3:0] d;
    int         hi;
    int         v;
    logic [7:0] b;
    logic       brs;
    int         we;
    logic [6:0] wa;
    logic [7:0] wd;
    logic [6:0] a;
    logic       m4;
    int         clr;
  } vec_t;

  vec_t vt[28];

  initial begin
    int b0, w0, c0;

    // r   d    hi v  byte   rs  we wa     wd     addr   m4  clr
    vt[0]  = '{0, 4'h3, 5, 1, 8'h30, 0, 0, 7'h00, 8'h00, 7'h00, 0, 0};
    vt[1]  = '{0, 4'h3, 5, 1, 8'h30, 0, 0, 7'h00, 8'h00, 7'h00, 0, 0};
    vt[2]  = '{0, 4'h3, 5, 1, 8'h30, 0, 0, 7'h00, 8'h00, 7'h00, 0, 0};
    vt[3]  = '{0, 4'h2, 5, 1, 8'h20, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[4]  = '{0, 4'h8, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[5]  = '{0, 4'h5, 5, 1, 8'h85, 0, 0, 7'h00, 8'h00, 7'h05, 1, 0};
    vt[6]  = '{1, 4'h4, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h05, 1, 0};
    vt[7]  = '{1, 4'h1, 5, 1, 8'h41, 1, 1, 7'h05, 8'h41, 7'h06, 1, 0};
    vt[8]  = '{0, 4'h0, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h06, 1, 0};
    vt[9]  = '{0, 4'h4, 5, 1, 8'h04, 0, 0, 7'h00, 8'h00, 7'h06, 1, 0};
    vt[10] = '{0, 4'h8, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h06, 1, 0};
    vt[11] = '{0, 4'h0, 5, 1, 8'h80, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[12] = '{1, 4'h4, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[13] = '{1, 4'h2, 5, 1, 8'h42, 1, 1, 7'h00, 8'h42, 7'h7F, 1, 0};
    vt[14] = '{0, 4'h0, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h7F, 1, 0};
    vt[15] = '{0, 4'h6, 5, 1, 8'h06, 0, 0, 7'h00, 8'h00, 7'h7F, 1, 0};
    vt[16] = '{0, 4'hF, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h7F, 1, 0};
    vt[17] = '{0, 4'hF, 5, 1, 8'hFF, 0, 0, 7'h00, 8'h00, 7'h7F, 1, 0};
    vt[18] = '{1, 4'h3, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h7F, 1, 0};
    vt[19] = '{1, 4'h0, 5, 1, 8'h30, 1, 1, 7'h7F, 8'h30, 7'h00, 1, 0};
    vt[20] = '{0, 4'h8, 3, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[21] = '{0, 4'h9, 4, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[22] = '{0, 4'h1, 4, 1, 8'h91, 0, 0, 7'h00, 8'h00, 7'h11, 1, 0};
    vt[23] = '{0, 4'h0, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h11, 1, 0};
    vt[24] = '{0, 4'h1, 5, 1, 8'h01, 0, 0, 7'h00, 8'h00, 7'h00, 1, 1};
    vt[25] = '{0, 4'h3, 5, 0, 8'h00, 0, 0, 7'h00, 8'h00, 7'h00, 1, 0};
    vt[26] = '{0, 4'h0, 5, 1, 8'h30, 0, 0, 7'h00, 8'h00, 7'h00, 0, 0};
    vt[27] = '{0, 4'h3, 5, 1, 8'h30, 0, 0, 7'h00, 8'h00, 7'h00, 0, 0};

    lcd.e  = 1'b0;
    lcd.rs = 1'b0;
    lcd.db = 4'h0;
    rst    = 1'b1;
    do_reset();

    check("rst_mode4", {31'd0, mode4}, 32'd0);
    check("rst_addr", {25'd0, addr}, 32'd0);
    check("rst_pulses", {28'd0, byte_valid, ddram_we, clear_pulse, busy},
          32'd0);
    check("rst_err", {31'd0, err_busy}, 32'd0);

`ifndef HD44780_SINK_BUSY_EN
    for (int i = 0; i < 28; i++) begin
      b0 = bv_cnt;
      w0 = we_cnt;
      c0 = clr_cnt;
      send(vt[i].r, vt[i].d, vt[i].hi);
      check($sformatf("v%0d_valid", i), bv_cnt - b0, vt[i].v);
      if (vt[i].v != 0) begin
        check($sformatf("v%0d_byte", i), {24'd0, last_byte}, {24'd0, vt[i].b});
        check($sformatf("v%0d_rs", i), {31'd0, last_rs}, {31'd0, vt[i].brs});
      end
      check($sformatf("v%0d_we", i), we_cnt - w0, vt[i].we);
      if (vt[i].we != 0) begin
        check($sformatf("v%0d_waddr", i), {25'd0, last_wa}, {25'd0, vt[i].wa});
        check($sformatf("v%0d_wdata", i), {24'd0, last_wd}, {24'd0, vt[i].wd});
      end
      check($sformatf("v%0d_addr", i), {25'd0, addr}, {25'd0, vt[i].a});
      check($sformatf("v%0d_mode4", i), {31'd0, mode4}, {31'd0, vt[i].m4});
      check($sformatf("v%0d_clr", i), clr_cnt - c0, vt[i].clr);
      check($sformatf("v%0d_busy", i), {30'd0, busy, err_busy}, 32'd0);
    end

    // Reset between nibbles drops the held high nibble and returns to INIT8.
    send(0, 4'h2, 5);
    check("mid_mode4_pre", {31'd0, mode4}, 32'd1);
    send(0, 4'h8, 5);
    do_reset();
    check("mid_mode4", {31'd0, mode4}, 32'd0);
    check("mid_addr", {25'd0, addr}, 32'd0);
    b0 = bv_cnt;
    send(0, 4'h3, 5);
    check("mid_valid", bv_cnt - b0, 1);
    check("mid_byte", {24'd0, last_byte}, 32'h30);
`else
    b0 = bv_cnt;
    send(0, 4'h3, 5);
    check("busy_set", {31'd0, busy}, 32'd1);
    check("busy_err0", {31'd0, err_busy}, 32'd0);
    send(0, 4'h3, 5);
    check("busy_still_processed", bv_cnt - b0, 2);
    check("busy_err1", {31'd0, err_busy}, 32'd1);
    do_reset();
    check("busy_rst_err", {31'd0, err_busy}, 32'd0);
    send(0, 4'h2, 5);
    repeat (70) @(negedge clk);
    check("busy_expired", {31'd0, busy}, 32'd0);
    send(0, 4'h8, 5);
    send(0, 4'h5, 5);
    check("busy_ac5", {25'd0, addr}, 32'h05);
    repeat (70) @(negedge clk);
    c0 = clr_cnt;
    send(0, 4'h0, 5);
    send(0, 4'h1, 5);
    check("clr_pulse", clr_cnt - c0, 1);
    check("clr_addr", {25'd0, addr}, 32'd0);
    check("clr_busy0", {31'd0, busy}, 32'd1);
    repeat (240) @(negedge clk);
    check("clr_busy240", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    check("clr_busy_end", {31'd0, busy}, 32'd0);
    check("clr_no_err", {31'd0, err_busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hd44780_sink.md
Name: hd44780_sink

Overview:
- Panel-side model of the HD44780 4-bit write interface: the receiving end of the e/rs/db bus that the hd44780 driver produces.
- Oversamples e/rs/db on the system clock and detects E falling-edge strobes.
- Tracks the controller's 8-bit-init to 4-bit interface mode, assembles nibbles into bytes, decodes instructions and maintains the DDRAM address counter.
- Emits a DDRAM write port; used as an on-chip loopback/checker and as a bench responder.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer on e, rs and db; minimum 2.
- E_MIN_HIGH, 4, minimum consecutive synchronized-high cycles of e for a strobe to count; shorter pulses are ignored as glitches.
- BUSY_CYCLES, 64, busy duration after each accepted byte (optional feature only).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- e  in  1  HD44780 enable strobe (asynchronous to clk).
- rs  in  1  register select: 0 = instruction, 1 = data.
- db  in  4  data bus DB7..DB4.
- mode4  out  1  1 = 4-bit interface active.
- byte_valid  out  1  one-cycle pulse: byte_out/byte_rs valid.
- byte_out  out  8  assembled byte.
- byte_rs  out  1  rs value associated with byte_out.
- ddram_we  out  1  one-cycle DDRAM write strobe.
- ddram_addr  out  7  write address.
- ddram_wdata  out  8  write data.
- addr  out  7  current address counter (AC).
- clear_pulse  out  1  one-cycle pulse on a Clear Display instruction.
- busy  out  1  busy flag (optional feature).
- err_busy  out  1  sticky: strobe accepted while busy (optional feature).

Behaviour:
- Reset values: all outputs 0 except mode4=0; internal state INIT8, increment flag ID=1, high counter 0, nibble latch 0.
- Synchronizer: e, rs and db each pass through SYNC_STAGES flops; e_s, rs_s, db_s denote the outputs.
- High counter: counts consecutive cycles with e_s=1, saturating at E_MIN_HIGH. rs_s and db_s are latched every cycle while e_s=1, so the latched values are those of the last high cycle.
- Strobe: first cycle with e_s=0 after e_s=1, and only if the counter reached E_MIN_HIGH; the counter clears on that cycle.
- Output timing: all resulting outputs are registered and pulse exactly one cycle, in the cycle after the strobe cycle.
- State INIT8 (8-bit interface):
  - Each strobe forms a byte = {db,4'b0000} and outputs it with byte_valid.
  - If rs=0 and byte[7:5]=3'b001 with DL (byte[4])=0: go to NIB_HI and set mode4=1.
- State NIB_HI (4-bit): strobe stores the high nibble and rs; go to NIB_LO. No output.
- State NIB_LO (4-bit): strobe forms byte = {stored_hi, db}; byte_rs = stored rs (the low-nibble rs is ignored). Output byte_valid and decode.
  - Then go to NIB_HI, or to INIT8 with mode4=0 if the byte is Function Set (rs=0, byte[7:5]=001) with DL=1.
- Decode, applied in the same cycle as byte_valid:
  - rs=1 (data write): ddram_we=1, ddram_addr=AC, ddram_wdata=byte. Then AC = AC+1 if ID=1, else AC-1, 7-bit modulo (0x7F+1 gives 0x00; 0x00-1 gives 0x7F).
  - 0x01 (Clear Display): AC=0, ID=1, clear_pulse=1.
  - 0x02/0x03 (Return Home): AC=0.
  - 0x04..0x07 (Entry Mode Set): ID=byte[1]; shift bit ignored.
  - byte[7]=1 (Set DDRAM Address): AC=byte[6:0].
  - All other instructions: byte_valid only, no state change.
- addr always reflects the updated AC value from the cycle after the decode.
- Reset mid-byte: a pending high nibble is discarded; return to INIT8.
- An e rising edge during a pulse cycle has no effect on that pulse.

Optional Feature:
- Macro HD44780_SINK_BUSY_EN.
- Defined:
  - busy goes to 1 with byte_valid and stays high for BUSY_CYCLES cycles.
  - Any strobe while busy=1 sets err_busy (sticky until rst) but is still processed.
  - A busy restart reloads the counter.
  - Clear Display holds busy for 4*BUSY_CYCLES.
- Undefined: busy and err_busy are tied to 0; no counter logic.

Test Plan:
- Reset, no strobes -> mode4=0, addr=0x00, all pulses 0, state INIT8.
- INIT8 strobes db=0x3, 0x3, 0x3, then 0x2 (rs=0) -> byte_out 0x30, 0x30, 0x30, 0x20; mode4=1 after the fourth strobe.
- mode4=1; nibbles 0x8,0x5 (rs=0), then 0x4,0x1 (rs=1) -> AC=0x05, then ddram_we with ddram_addr=0x05, ddram_wdata=0x41; addr=0x06.
- Entry mode 0x04, then data at AC=0x00 -> write to address 0x00, addr=0x7F. Then Set Address 0xFF followed by ID=1 data -> addr wraps to 0x00.
- E pulse of E_MIN_HIGH-1 synchronized cycles -> no byte_valid, nibble phase unchanged. Pulse of exactly E_MIN_HIGH cycles -> accepted.
- With HD44780_SINK_BUSY_EN: strobe 10 cycles after a byte -> busy=1, err_busy=1. Clear 0x01 -> clear_pulse=1, addr=0, busy held 256 cycles.
